regfile_clr_bank: RTL and testbench

- Parametrised successor to the single-register clearable cell.
- Holds a DEPTH x BITWIDTH register bank with:
  - one write port;
  - two combinational read ports;
  - a per-entry valid bit.
- Bulk clear is a sequenced sweep FSM that clears one entry per cycle. Writes are held off while the sweep runs.
- Used for per-wavefront bookkeeping state that must be wiped between dispatches without a wide single-cycle clear.

---
 rtl/regfile_clr_bank.sv | 161 ++++++++++++++++
 tb/tb_regfile_clr_bank.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_clr_bank.sv
// ============================================================================
// Module   : regfile_clr_bank
// Purpose  : DEPTH x BITWIDTH register bank with one write port, two
//            combinational read ports, per-entry valid bits and a sequenced
//            one-entry-per-cycle bulk-clear sweep.
// Option   : REGFILE_CLR_BYPASS_EN enables write-through read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_clr_bank #(
    parameter int                   BITWIDTH  = 11,
    parameter int                   DEPTH     = 16,
    parameter int                   ADDR_W    = 4,
    parameter logic [BITWIDTH-1:0]  CLR_VALUE = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [BITWIDTH-1:0] wr_data,
    output logic                wr_ready,
    input  logic [ADDR_W-1:0]   rd_addr_a,
    output logic [BITWIDTH-1:0] rd_data_a,
    output logic                rd_valid_a,
    input  logic [ADDR_W-1:0]   rd_addr_b,
    output logic [BITWIDTH-1:0] rd_data_b,
    output logic                rd_valid_b,
    input  logic                clr_req,
    output logic                clr_busy,
    output logic                clr_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    logic [ADDR_W-1:0]      r_ptr;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_wr_ready;
    logic [BITWIDTH-1:0]    r_mem [DEPTH];
    logic [DEPTH-1:0]       r_valid;

    logic                   w_wr_acc;
    logic                   w_sweep_clr;
    logic                   w_ptr_last;
    logic [BITWIDTH-1:0]    w_rd_data_a;
    logic [BITWIDTH-1:0]    w_rd_data_b;
    logic                   w_rd_valid_a;
    logic                   w_rd_valid_b;

    assign w_wr_acc    = rst && wr_en && r_wr_ready && (int'(wr_addr) < DEPTH);
    assign w_sweep_clr = (r_state == ST_SWEEP);
    assign w_ptr_last  = (int'(r_ptr) == DEPTH - 1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_ready <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (clr_req) begin
                        r_state    <= ST_SWEEP;
                        r_ptr      <= '0;
                        r_busy     <= 1'b1;
                        r_wr_ready <= 1'b0;
                    end
                end
                ST_SWEEP: begin
                    r_ptr <= r_ptr + ADDR_W'(1);
                    if (w_ptr_last) begin
                        r_state <= ST_DONE;
                        r_done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state    <= ST_IDLE;
                    r_ptr      <= '0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_wr_ready <= 1'b1;
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_ptr      <= '0;
                    r_done     <= 1'b0;
                    r_busy     <= 1'b0;
                    r_wr_ready <= 1'b1;
                end
            endcase
        end
    end

    // Writes are only accepted in IDLE, so sweep and write never hit the
    // same cycle; the sweep still takes priority for robustness.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= CLR_VALUE;
            end
            r_valid <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_sweep_clr && (int'(r_ptr) == i)) begin
                    r_mem[i]   <= CLR_VALUE;
                    r_valid[i] <= 1'b0;
                end else if (w_wr_acc && (int'(wr_addr) == i)) begin
                    r_mem[i]   <= wr_data;
                    r_valid[i] <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_rd_data_a  = CLR_VALUE;
        w_rd_valid_a = 1'b0;
        w_rd_data_b  = CLR_VALUE;
        w_rd_valid_b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (int'(rd_addr_a) == i) begin
                w_rd_data_a  = r_mem[i];
                w_rd_valid_a = r_valid[i];
            end
            if (int'(rd_addr_b) == i) begin
                w_rd_data_b  = r_mem[i];
                w_rd_valid_b = r_valid[i];
            end
        end
`ifdef REGFILE_CLR_BYPASS_EN
        if (w_wr_acc && (rd_addr_a == wr_addr)) begin
            w_rd_data_a  = wr_data;
            w_rd_valid_a = 1'b1;
        end
        if (w_wr_acc && (rd_addr_b == wr_addr)) begin
            w_rd_data_b  = wr_data;
            w_rd_valid_b = 1'b1;
        end
`else
`endif
    end

    assign rd_data_a  = w_rd_data_a;
    assign rd_valid_a = w_rd_valid_a;
    assign rd_data_b  = w_rd_data_b;
    assign rd_valid_b = w_rd_valid_b;
    assign wr_ready   = r_wr_ready;
    assign clr_busy   = r_busy;
    assign clr_done   = r_done;

endmodule

`default_nettype wire

// File: tb/tb_regfile_clr_bank.sv
// ============================================================================
// Module   : tb_regfile_clr_bank
// Purpose  : Self-checking bench for regfile_clr_bank (ADDR_W=5 build so that
//            out-of-range addresses can be exercised).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_regfile_clr_bank;

    localparam int BW    = 11;
    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [BW-1:0] wr_data = '0;
    logic          wr_ready;
    logic [AW-1:0] rd_addr_a = '0;
    logic [BW-1:0] rd_data_a;
    logic          rd_valid_a;
    logic [AW-1:0] rd_addr_b = '0;
    logic [BW-1:0] rd_data_b;
    logic          rd_valid_b;
    logic          clr_req = 1'b0;
    logic          clr_busy;
    logic          clr_done;

    regfile_clr_bank #(
        .BITWIDTH (BW),
        .DEPTH    (DEPTH),
        .ADDR_W   (AW),
        .CLR_VALUE('0)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_addr_a (rd_addr_a),
        .rd_data_a (rd_data_a),
        .rd_valid_a(rd_valid_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_b (rd_data_b),
        .rd_valid_b(rd_valid_b),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .clr_done  (clr_done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: contents, valid bits, and "cycles since clear
    // accepted" (0 = idle; 1..DEPTH clears entry sw-1; DEPTH+1 = done cycle).
    logic [BW-1:0] m_mem [DEPTH];
    bit            m_val [DEPTH];
    int            sw;

    function automatic void model_reset();
        for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = '0;
            m_val[i] = 1'b0;
        end
        sw = 0;
    endfunction

    function automatic bit wr_accepted();
        return rst && wr_en && (sw == 0) && (int'(wr_addr) < DEPTH);
    endfunction

    function automatic void exp_rd(input int a, output logic [BW-1:0] d, output logic v);
        d = '0;
        v = 1'b0;
        if (a < DEPTH) begin
            d = m_mem[a];
            v = m_val[a];
        end
`ifdef REGFILE_CLR_BYPASS_EN
        if (wr_accepted() && (a == int'(wr_addr))) begin
            d = wr_data;
            v = 1'b1;
        end
`endif
    endfunction

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [BW-1:0] ea, eb;
        logic          va, vb;
        #1;
        exp_rd(int'(rd_addr_a), ea, va);
        exp_rd(int'(rd_addr_b), eb, vb);
        cmp({tag, ".rd_data_a"},  32'(rd_data_a),  32'(ea));
        cmp({tag, ".rd_valid_a"}, 32'(rd_valid_a), 32'(va));
        cmp({tag, ".rd_data_b"},  32'(rd_data_b),  32'(eb));
        cmp({tag, ".rd_valid_b"}, 32'(rd_valid_b), 32'(vb));
        cmp({tag, ".wr_ready"},   32'(wr_ready),   32'(sw == 0));
        cmp({tag, ".clr_busy"},   32'(clr_busy),   32'(sw != 0));
        cmp({tag, ".clr_done"},   32'(clr_done),   32'(sw == DEPTH + 1));
    endtask

    task automatic tick();
        bit            acc;
        int            wa, nsw, clr_idx;
        logic [BW-1:0] wd;
        acc     = wr_accepted();
        wa      = int'(wr_addr);
        wd      = wr_data;
        clr_idx = -1;
        if (sw == 0)          nsw = clr_req ? 1 : 0;
        else if (sw <= DEPTH) begin clr_idx = sw - 1; nsw = sw + 1; end
        else                  nsw = 0;
        @(posedge clk);
        #1;
        if (!rst) begin
            model_reset();
        end else begin
            if (acc) begin
                m_mem[wa] = wd;
                m_val[wa] = 1'b1;
            end
            if (clr_idx >= 0) begin
                m_mem[clr_idx] = '0;
                m_val[clr_idx] = 1'b0;
            end
            sw = nsw;
        end
    endtask

    task automatic step(input string tag);
        check_all(tag);
        tick();
    endtask

    task automatic drive(input logic en, input int a, input int d);
        wr_en   = en;
        wr_addr = AW'(a);
        wr_data = BW'(d);
    endtask

    task automatic sweep_all(input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            rd_addr_a = AW'(i);
            rd_addr_b = AW'(DEPTH - 1 - i);
            check_all(tag);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        sweep_all("reset");
        rst = 1'b1;
        #1;

        // Directed writes and an out-of-range write
        drive(1, 3, 'h5A3);  step("wr3");
        drive(1, 15, 'h7FF); step("wr15");
        wr_en = 1'b0; rd_addr_a = 3; rd_addr_b = 15;
        check_all("rd3_15");
        cmp("rd3_const",  32'(rd_data_a), 32'h5A3);
        cmp("rd15_const", 32'(rd_data_b), 32'h7FF);
        drive(1, 16, 'h3C3); step("wr16");
        wr_en = 1'b0;
        sweep_all("after_wr16");
        rd_addr_a = 16; rd_addr_b = 31;
        check_all("rd_oor");

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 1), $urandom_range(0, 19), $urandom);
            rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 19));
            rd_addr_b = AW'($urandom_range(0, 19));
            clr_req   = ($urandom_range(0, 19) == 0);
            step("rand");
        end
        clr_req = 1'b0; wr_en = 1'b0;
        for (int n = 0; n < 40 && sw != 0; n++) step("drain");
        cmp("drain_idle", 32'(wr_ready), 32'd1);

        // Directed sweep with held write and ignored clr_req
        for (int i = 0; i < DEPTH; i++) begin
            drive(1, i, i * 'h41);
            step("fill");
        end
        wr_en = 1'b0;
        clr_req = 1'b1;
        step("clr_N");
        clr_req = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (k == 2)  drive(1, 5, 'h123);
            if (k == 19) wr_en = 1'b0;
            clr_req = (k == 4);
            if (k == 6)  begin rd_addr_a = 2; rd_addr_b = 10; end
            if (k == 19) rd_addr_a = 5;
            check_all("sweep");
            cmp("sweep_busy",  32'(clr_busy), 32'(k >= 1 && k <= 17));
            cmp("sweep_done",  32'(clr_done), 32'(k == 17));
            cmp("sweep_ready", 32'(wr_ready), 32'(k >= 18));
            if (k == 6) begin
                cmp("mid_e2_data",  32'(rd_data_a),  32'h000);
                cmp("mid_e2_valid", 32'(rd_valid_a), 32'd0);
                cmp("mid_e10_data", 32'(rd_data_b),  32'h28A);
                cmp("mid_e10_valid",32'(rd_valid_b), 32'd1);
            end
            if (k == 19) begin
                cmp("held_wr_data",  32'(rd_data_a),  32'h123);
                cmp("held_wr_valid", 32'(rd_valid_a), 32'd1);
            end
            tick();
        end
        sweep_all("post_sweep");

        // Asynchronous reset in the middle of a sweep
        for (int i = 0; i < 6; i++) begin
            drive(1, i * 2, $urandom);
            step("pre_abort");
        end
        wr_en = 1'b0;
        clr_req = 1'b1;
        step("abort_N");
        clr_req = 1'b0;
        for (int k = 1; k < 8; k++) step("abort_run");
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        cmp("async_busy",  32'(clr_busy), 32'd0);
        cmp("async_done",  32'(clr_done), 32'd0);
        cmp("async_ready", 32'(wr_ready), 32'd1);
        rd_addr_a = 0; rd_addr_b = 10;
        #1;
        cmp("async_rd_valid_b", 32'(rd_valid_b), 32'd0);
        for (int k = 0; k < 3; k++) tick();
        sweep_all("in_reset");
        #2;
        rst = 1'b1;
        for (int k = 0; k < 20; k++) step("after_abort");

        // Same-cycle write and read of one entry
        drive(1, 7, 'h155); step("bp_pre");
        drive(1, 7, 'h0AA); rd_addr_a = 7; rd_addr_b = 7;
        check_all("bp_same");
`ifdef REGFILE_CLR_BYPASS_EN
        cmp("bp_same_const", 32'(rd_data_a), 32'h0AA);
`else
        cmp("bp_same_const", 32'(rd_data_a), 32'h155);
`endif
        tick();
        wr_en = 1'b0;
        check_all("bp_next");
        cmp("bp_next_const", 32'(rd_data_a), 32'h0AA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
